// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction queue between fetch and decode.
//
// Captures (pc, insn) pairs from fetch and presents them show-ahead to
// decode. Both sides use a valid/ready handshake. ready_o and valid_o are
// decoded purely from the registered occupancy count, so neither side sees
// a combinational path from the other side's handshake. A synchronous
// flush drops everything on a redirect.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active low
//   pc_i     PC offered by fetch
//   insn_i   instruction offered by fetch
//   valid_i  fetch offers pc_i/insn_i
//   ready_o  queue can accept an entry this cycle (not full)
//   pc_o     PC at queue head
//   insn_o   instruction at queue head
//   valid_o  head entry is valid (not empty)
//   ready_i  decode consumes the head
//   flush_i  discard all entries at the next edge
//   count_o  number of valid entries (0..DEPTH)
//
// DEPTH must be a power of two and >= 2: pointers wrap by natural overflow.

// One storage slot. Cleared on reset so the head reads zero out of reset.
module fq_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end

endmodule

module fetch_queue #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AWIDTH-1:0]        pc_i,
  input  logic [DWIDTH-1:0]        insn_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [AWIDTH-1:0]        pc_o,
  output logic [DWIDTH-1:0]        insn_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AWIDTH + DWIDTH;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  // Occupancy view of count; purely a decode, no extra state.
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  occ_t                       occ;
  logic                       enq, deq;
  logic [DEPTH-1:0]           we;
  logic [DEPTH-1:0][EW-1:0]   mem_q;
  entry_t                     wr_ent, head;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)              occ = OCC_EMPTY;
    else if (count == CW'(DEPTH)) occ = OCC_FULL;
  end

  assign ready_o = (occ != OCC_FULL);
  assign valid_o = (occ != OCC_EMPTY);
  assign count_o = count;

  // A flushed cycle never writes, so a dropped enqueue cannot resurface.
  // A same-cycle dequeue is still taken by decode; the flush simply
  // overrides its pointer/count effect.
  assign enq = valid_i & ready_o & ~flush_i;
  assign deq = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign wr_ent.pc   = pc_i;
  assign wr_ent.insn = insn_i;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign we[i] = enq && (wr_ptr == PW'(i));
      fq_entry #(.W(EW)) u_entry (
        .clk (clk),
        .rst (rst),
        .we  (we[i]),
        .d   (wr_ent),
        .q   (mem_q[i])
      );
    end
  endgenerate

  // Show-ahead read; no write bypass, so new data appears one edge later.
  assign head   = entry_t'(mem_q[rd_ptr]);
  assign pc_o   = head.pc;
  assign insn_o = head.insn;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_i;
  logic [DW-1:0] insn_i;
  logic          valid_i;
  logic          ready_o;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] insn_o;
  logic          valid_o;
  logic          ready_i;
  logic          flush_i;
  logic [2:0]    count_o;

  fetch_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_i    (pc_i),
    .insn_i  (insn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pc_o    (pc_o),
    .insn_o  (insn_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .flush_i (flush_i),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] insn;
    bit          rdy;
    bit          fl;
    int          exp_cnt;   // count_o expected after the edge
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, logic [31:0] pc, bit rdy, bit fl, int c);
    vec_t r;
    r.v = v; r.pc = pc; r.insn = pc ^ 32'h5a5a_0013; r.rdy = rdy; r.fl = fl; r.exp_cnt = c;
    return r;
  endfunction

  // One cycle: drive at posedge+1, check state and update scoreboard at
  // negedge, then check count after the next edge.
  task automatic step(input vec_t t);
    bit   m_valid, m_ready, enq, deq;
    ent_t e;
    valid_i = t.v; pc_i = t.pc; insn_i = t.insn; ready_i = t.rdy; flush_i = t.fl;
    @(negedge clk);
    m_valid = (sb.size() != 0);
    m_ready = (sb.size() != DEPTH);
    chk("valid_o", 64'(valid_o), 64'(m_valid));
    chk("ready_o", 64'(ready_o), 64'(m_ready));
    chk("count_o_model", 64'(count_o), 64'(sb.size()));
    if (m_valid) begin
      chk("head_pc", 64'(pc_o), 64'(sb[0].pc));
      chk("head_insn", 64'(insn_o), 64'(sb[0].insn));
    end
    deq = m_valid && t.rdy;
    enq = t.v && m_ready;
    if (t.fl) sb.delete();
    else begin
      if (deq) void'(sb.pop_front());
      if (enq) begin e.pc = t.pc; e.insn = t.insn; sb.push_back(e); end
    end
    @(posedge clk); #1;
    chk("count_o_table", 64'(count_o), 64'(t.exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    // Single pass
    t = mk(1, 32'h0100_0000, 1, 0, 1); t.insn = 32'h0050_0093; vecs.push_back(t);
    vecs.push_back(mk(0, 32'h0, 1, 0, 0));
    // Fill with decode stalled
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 32'h0100_0000 + 32'(4*i), 0, 0, i + 1));
    vecs.push_back(mk(1, 32'h0100_0010, 0, 0, 4));  // 5th offer refused
    vecs.push_back(mk(1, 32'h0100_0010, 1, 0, 3));  // full: refused even with dequeue
    for (int i = 2; i >= 0; i--) vecs.push_back(mk(0, 32'h0, 1, 0, i));
    // Steady enq/deq at count 2, pointers wrap several times
    vecs.push_back(mk(1, 32'h0100_0100, 0, 0, 1));
    vecs.push_back(mk(1, 32'h0100_0104, 0, 0, 2));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 32'h0100_0108 + 32'(4*i), 1, 0, 2));
    // Flush at count 3 with a same-cycle offer and dequeue
    vecs.push_back(mk(1, 32'h0100_0130, 0, 0, 3));
    vecs.push_back(mk(1, 32'h0100_0020, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h0100_0040, 1, 0, 1));   // refill after flush
    vecs.push_back(mk(0, 32'h0, 1, 0, 0));

    valid_i = 0; pc_i = '0; insn_i = '0; ready_i = 0; flush_i = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_count_o", 64'(count_o), 64'd0);
    chk("rst_pc_o", 64'(pc_o), 64'd0);
    chk("rst_insn_o", 64'(insn_o), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) step(vecs[i]);

    // Reset dropped between edges with three entries buffered
    for (int i = 0; i < 3; i++) step(mk(1, 32'h0100_0180 + 32'(4*i), 0, 0, i + 1));
    valid_i = 0; ready_i = 0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid_o", 64'(valid_o), 64'd0);
    chk("midrst_count_o", 64'(count_o), 64'd0);
    chk("midrst_ready_o", 64'(ready_o), 64'd1);
    chk("midrst_pc_o", 64'(pc_o), 64'd0);
    sb.delete();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    step(mk(1, 32'h0100_0200, 0, 0, 1));
    step(mk(0, 32'h0, 1, 0, 0));
    step(mk(0, 32'h0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
